// File: rtl/product_seq_pkg.sv
// Shared types and width helpers for product_mac_sequencer.
package product_seq_pkg;

  localparam int unsigned DEF_NUM_TAPS = 8;
  localparam int unsigned DEF_DATA_W   = 12;
  localparam int unsigned DEF_COEF_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_DRAIN,
    ST_HOLD
  } seq_state_t;

  // Wide enough that NUM_TAPS full-scale products can never overflow.
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned coef_w,
                                            input int unsigned num_taps);
    return data_w + coef_w + $clog2(num_taps);
  endfunction

endpackage

// File: rtl/product_mac_sequencer_lane.sv
// product_lane: registered unsigned COEF_W x DATA_W multiply with synchronous clear.
module product_lane #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned COEF_W = 2
) (
  input  logic                     ip_clock,
  input  logic                     ip_reset,
  input  logic                     ip_clear,
  input  logic                     ip_enable,
  input  logic [COEF_W-1:0]        ip_coef,
  input  logic [DATA_W-1:0]        ip_data,
  output logic [DATA_W+COEF_W-1:0] op_product
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;

  always_ff @(posedge ip_clock) begin
    if (ip_reset || ip_clear) begin
      op_product <= '0;
    end else if (ip_enable) begin
      op_product <= PROD_W'(ip_coef) * PROD_W'(ip_data);
    end
  end

endmodule

// File: rtl/product_mac_sequencer.sv
// Sequential dot product of a sample delay line against latched coefficients.
// Optional rounding/saturation of the result under PRODUCT_SEQ_ROUND_EN.
module product_mac_sequencer
  import product_seq_pkg::*;
#(
  parameter int unsigned NUM_TAPS = DEF_NUM_TAPS,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned COEF_W   = DEF_COEF_W
) (
  input  logic                       ip_clock,
  input  logic                       ip_reset,
  input  logic [DATA_W-1:0]          ip_data,
  input  logic                       ip_data_valid,
  output logic                       op_data_ready,
  input  logic [NUM_TAPS*COEF_W-1:0] ip_coef,
  input  logic                       ip_clear,
  output logic [DATA_W-1:0]          op_result,
  output logic                       op_result_valid,
  input  logic                       ip_result_ready,
  output logic                       op_busy
);

  localparam int unsigned ACC_W  = acc_width(DATA_W, COEF_W, NUM_TAPS);
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned CNT_W  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int unsigned SHIFT  = ACC_W - DATA_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TAPS - 1);

  seq_state_t        state;
  logic [DATA_W-1:0] taps  [NUM_TAPS];
  logic [COEF_W-1:0] coefs [NUM_TAPS];
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [PROD_W-1:0] product;
  logic              accept;
  logic              issue;
  logic [ACC_W-1:0]  acc_sum;
  logic [DATA_W-1:0] result_next;

  assign op_data_ready = (state == ST_IDLE);
  assign op_busy       = (state != ST_IDLE);
  assign accept        = ip_data_valid && (state == ST_IDLE);
  assign issue         = (state == ST_MAC);
  assign acc_sum       = acc + ACC_W'(product);

`ifdef PRODUCT_SEQ_ROUND_EN
  logic [ACC_W:0] rounded;
  assign rounded     = {1'b0, acc_sum} + ((ACC_W + 1)'(1) << (SHIFT - 1));
  assign result_next = rounded[ACC_W] ? '1 : DATA_W'(rounded >> SHIFT);
`else
  assign result_next = DATA_W'(acc_sum >> SHIFT);
`endif

  // Lane is cleared on accept so the first MAC-cycle accumulate adds zero.
  product_lane #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W)
  ) u_lane (
    .ip_clock   (ip_clock),
    .ip_reset   (ip_reset),
    .ip_clear   (accept),
    .ip_enable  (issue),
    .ip_coef    (coefs[cnt]),
    .ip_data    (taps[cnt]),
    .op_product (product)
  );

  always_ff @(posedge ip_clock) begin
    if (ip_reset) begin
      state           <= ST_IDLE;
      acc             <= '0;
      cnt             <= '0;
      op_result       <= '0;
      op_result_valid <= 1'b0;
      for (int unsigned k = 0; k < NUM_TAPS; k++) begin
        taps[k]  <= '0;
        coefs[k] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            // Clear-with-accept zeroes the line before the new sample lands.
            taps[0] <= ip_data;
            for (int unsigned k = 1; k < NUM_TAPS; k++) begin
              taps[k] <= ip_clear ? '0 : taps[k-1];
            end
            for (int unsigned k = 0; k < NUM_TAPS; k++) begin
              coefs[k] <= ip_coef[k*COEF_W +: COEF_W];
            end
            acc   <= '0;
            cnt   <= '0;
            state <= ST_MAC;
          end else if (ip_clear) begin
            for (int unsigned k = 0; k < NUM_TAPS; k++) begin
              taps[k] <= '0;
            end
          end
        end
        ST_MAC: begin
          acc <= acc_sum;
          if (cnt == LAST_CNT) begin
            cnt   <= '0;
            state <= ST_DRAIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          acc             <= acc_sum;
          op_result       <= result_next;
          op_result_valid <= 1'b1;
          state           <= ST_HOLD;
        end
        ST_HOLD: begin
          if (ip_result_ready) begin
            op_result_valid <= 1'b0;
            state           <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_product_mac_sequencer.sv
// Directed, table-driven bench for product_mac_sequencer (NUM_TAPS=8).
module tb_product_mac_sequencer;

  logic        ip_clock = 1'b0;
  logic        ip_reset;
  logic [11:0] ip_data;
  logic        ip_data_valid;
  logic        op_data_ready;
  logic [15:0] ip_coef;
  logic        ip_clear;
  logic [11:0] op_result;
  logic        op_result_valid;
  logic        ip_result_ready;
  logic        op_busy;

  int unsigned total = 0;
  int unsigned bad   = 0;

  product_mac_sequencer #(
    .NUM_TAPS(8),
    .DATA_W  (12),
    .COEF_W  (2)
  ) dut (
    .ip_clock        (ip_clock),
    .ip_reset        (ip_reset),
    .ip_data         (ip_data),
    .ip_data_valid   (ip_data_valid),
    .op_data_ready   (op_data_ready),
    .ip_coef         (ip_coef),
    .ip_clear        (ip_clear),
    .op_result       (op_result),
    .op_result_valid (op_result_valid),
    .ip_result_ready (ip_result_ready),
    .op_busy         (op_busy)
  );

  always #5 ip_clock = ~ip_clock;

  typedef struct {
    logic [11:0] data;
    logic [15:0] coef;
    logic        clr;
    int unsigned hold;
    logic [11:0] exp_trunc;
    logic [11:0] exp_round;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ip_clock);
    #1;
  endtask

  // One accept, garbage on data/coef/clear while busy, optional stall in HOLD.
  task automatic do_txn(input string name, input logic [11:0] data, input logic [15:0] coef,
                        input logic clr, input int unsigned hold, input logic [11:0] exp);
    int unsigned lat;
    logic [11:0] held;
    ip_data         = data;
    ip_coef         = coef;
    ip_clear        = clr;
    ip_data_valid   = 1'b1;
    ip_result_ready = (hold == 0);
    check({name, " ready_idle"}, 32'(op_data_ready), 32'd1);
    tick();
    ip_data_valid = 1'b0;
    ip_clear      = 1'b1;
    ip_data       = 12'hABC;
    ip_coef       = 16'h1234;
    check({name, " busy"}, 32'(op_busy), 32'd1);
    check({name, " ready_busy"}, 32'(op_data_ready), 32'd0);
    lat = 0;
    while (!op_result_valid && lat < 30) begin
      tick();
      lat++;
    end
    check({name, " latency"}, lat, 32'd9);
    check({name, " result"}, 32'(op_result), 32'(exp));
    held = op_result;
    for (int i = 0; i < int'(hold); i++) begin
      ip_data       = 12'd777;
      ip_data_valid = 1'b1;
      tick();
      ip_data_valid = 1'b0;
      check({name, " hold_result"}, 32'(op_result), 32'(held));
      check({name, " hold_valid"}, 32'(op_result_valid), 32'd1);
      check({name, " hold_ready"}, 32'(op_data_ready), 32'd0);
    end
    ip_result_ready = 1'b1;
    tick();
    ip_clear = 1'b0;
    check({name, " valid_drop"}, 32'(op_result_valid), 32'd0);
    check({name, " idle"}, 32'(op_busy), 32'd0);
  endtask

  initial begin
    logic [11:0] exp;
    vecs[0]  = '{12'd1008, 16'h5555, 1'b0, 0, 12'd31,   12'd32};
    vecs[1]  = '{12'd4095, 16'hFFFF, 1'b1, 0, 12'd383,  12'd384};
    vecs[2]  = '{12'd4095, 16'hFFFF, 1'b0, 0, 12'd767,  12'd768};
    vecs[3]  = '{12'd4095, 16'hFFFF, 1'b0, 0, 12'd1151, 12'd1152};
    vecs[4]  = '{12'd4095, 16'hFFFF, 1'b0, 5, 12'd1535, 12'd1536};
    vecs[5]  = '{12'd4095, 16'hFFFF, 1'b0, 0, 12'd1919, 12'd1920};
    vecs[6]  = '{12'd4095, 16'hFFFF, 1'b0, 0, 12'd2303, 12'd2303};
    vecs[7]  = '{12'd4095, 16'hFFFF, 1'b0, 0, 12'd2687, 12'd2687};
    vecs[8]  = '{12'd4095, 16'hFFFF, 1'b0, 0, 12'd3071, 12'd3071};
    vecs[9]  = '{12'd100,  16'h0003, 1'b1, 0, 12'd9,    12'd9};
    vecs[10] = '{12'd200,  16'h000E, 1'b0, 0, 12'd21,   12'd22};
    vecs[11] = '{12'd4095, 16'h0030, 1'b0, 0, 12'd9,    12'd9};

    ip_reset        = 1'b1;
    ip_data         = '0;
    ip_data_valid   = 1'b0;
    ip_coef         = '0;
    ip_clear        = 1'b0;
    ip_result_ready = 1'b1;
    tick();
    tick();
    ip_reset = 1'b0;
    check("rst result", 32'(op_result), 32'd0);
    check("rst valid", 32'(op_result_valid), 32'd0);
    check("rst busy", 32'(op_busy), 32'd0);
    check("rst ready", 32'(op_data_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
`ifdef PRODUCT_SEQ_ROUND_EN
      exp = vecs[i].exp_round;
`else
      exp = vecs[i].exp_trunc;
`endif
      do_txn($sformatf("vec%0d", i), vecs[i].data, vecs[i].coef, vecs[i].clr, vecs[i].hold, exp);
    end

    // Reset while the MAC counter sits at 4.
    ip_data       = 12'd4095;
    ip_coef       = 16'hFFFF;
    ip_data_valid = 1'b1;
    tick();
    ip_data_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("mid busy", 32'(op_busy), 32'd1);
    ip_reset = 1'b1;
    tick();
    check("mrst busy", 32'(op_busy), 32'd0);
    check("mrst valid", 32'(op_result_valid), 32'd0);
    check("mrst result", 32'(op_result), 32'd0);
    ip_reset = 1'b0;
    check("mrst ready", 32'(op_data_ready), 32'd1);
`ifdef PRODUCT_SEQ_ROUND_EN
    exp = 12'd32;
`else
    exp = 12'd31;
`endif
    do_txn("post_rst", 12'd1008, 16'h5555, 1'b0, 0, exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/product_mac_sequencer.md
PRODUCT_MAC_SEQUENCER -- requirements
Module: product_mac_sequencer

Interface
REQ-001 SHALL have parameter NUM_TAPS, default 8: delay-line depth and number of MAC cycles per result.
REQ-002 SHALL have parameter DATA_W, default 12: sample and result width.
REQ-003 SHALL have parameter COEF_W, default 2: unsigned coefficient width.
REQ-004 SHALL have port ip_clock, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port ip_reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port ip_data, input, DATA_W: unsigned sample.
REQ-007 SHALL have port ip_data_valid, input, 1: sample offered.
REQ-008 SHALL have port op_data_ready, output, 1: sample may be accepted.
REQ-009 SHALL have port ip_coef, input, NUM_TAPS*COEF_W: flat coefficient vector; tap k at bits [k*COEF_W +: COEF_W].
REQ-010 SHALL have port ip_clear, input, 1: zero the delay line.
REQ-011 SHALL have port op_result, output, DATA_W: scaled dot product.
REQ-012 SHALL have port op_result_valid, output, 1: result held.
REQ-013 SHALL have port ip_result_ready, input, 1: downstream consumes result.
REQ-014 SHALL have port op_busy, output, 1: high in any state other than IDLE.

Function
REQ-015 SHALL run FSM states IDLE, MAC, DRAIN and HOLD.
REQ-016 In IDLE, op_data_ready SHALL be 1; accept occurs when ip_data_valid=1 and op_data_ready=1.
REQ-017 On accept, SHALL shift ip_data into tap[0], move tap[k] to tap[k+1], latch ip_coef, clear accumulator, set counter=0 and go to MAC.
REQ-018 In MAC, each cycle SHALL issue coef[cnt] x tap[cnt] to the shared product lane and increment cnt; after cnt=NUM_TAPS-1 it SHALL go to DRAIN.
REQ-019 Product lane SHALL be 1-cycle registered; accumulator SHALL add each lane result the cycle after issue, including in DRAIN.
REQ-020 DRAIN SHALL last 1 cycle and then go to HOLD; op_result_valid SHALL rise NUM_TAPS+1 cycles after the accepting edge.
REQ-021 Product width SHALL be DATA_W+COEF_W, unsigned; accumulator width ACC_W = DATA_W+COEF_W+clog2(NUM_TAPS) (17 by default), and it SHALL never overflow.
REQ-022 Without rounding, op_result SHALL equal acc[ACC_W-1 -: DATA_W], truncated.
REQ-023 In HOLD, op_result and op_result_valid SHALL stay stable until ip_result_ready=1; that cycle SHALL return the FSM to IDLE.
REQ-024 op_data_ready SHALL be 0 in MAC, DRAIN and HOLD; ip_data and ip_coef changes there SHALL have no effect.
REQ-025 ip_clear SHALL act only in IDLE; ip_clear together with accept SHALL zero the delay line first, then shift in ip_data.
REQ-026 ip_clear outside IDLE SHALL be ignored.

Reset
REQ-027 On ip_reset=1 at a rising edge, in any state (including mid-MAC), SHALL apply: state=IDLE, all taps, latched coefficients, accumulator, product register and counter=0.
REQ-028 During and after reset: op_result=0, op_result_valid=0, op_busy=0, op_data_ready=1 (once ip_reset=0).

Configuration
REQ-029 With PRODUCT_SEQ_ROUND_EN defined, SHALL add 2^(ACC_W-DATA_W-1) to the accumulator before truncation, saturating op_result at 2^DATA_W-1.
REQ-030 Without PRODUCT_SEQ_ROUND_EN, SHALL use plain truncation per REQ-022, with no rounding or saturation logic present.

Structure
REQ-031 Package product_seq_pkg SHALL hold the FSM state enum typedef, the ACC_W derivation function and default width constants.
REQ-032 SHALL instantiate exactly one sub-module, product_lane: a registered COEF_W x DATA_W unsigned multiply with synchronous clear.

Verification (NUM_TAPS=8)
REQ-033 Reset, then accept 1008 with all coef=1 and ip_result_ready=1: op_result_valid rises 9 cycles later with op_result=31 (32 with PRODUCT_SEQ_ROUND_EN).
REQ-034 Accept 8 samples of 4095 with all coef=3: 8th result = 98280>>5 = 3071 in both configurations.
REQ-035 Hold ip_result_ready=0 for 5 cycles in HOLD: op_result stays stable, op_data_ready=0, and ip_data_valid pulses are not accepted.
REQ-036 Assert ip_reset at MAC cnt=4: next cycle state=IDLE, outputs 0; the following single 1008/coef=1 accept gives 31.
REQ-037 Fill the line with 4095, then ip_clear with accept of 100, coef only tap0=3: result = 300>>5 = 9; ip_clear during MAC leaves the taps unchanged.
